// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM (Moore). Drives mux selects and write strobes for a
// shared-memory, single-ALU datapath, with configurable memory wait states and an illegal-instruction trap.
module mc_ctrl_fsm #(
    parameter int MEM_LATENCY = 2,
    parameter int ALU_OP_W    = 3,
    parameter int STATE_W     = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          op_code,
    input  logic [5:0]          funct,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                memory_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                alu_src_a,
    output logic [2:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_out_write,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    localparam int               CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    localparam logic [2:0] ALU_PASSA = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b001;
    localparam logic [2:0] ALU_SUB   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    localparam logic [2:0] SRC_B_REG     = 3'b000;
    localparam logic [2:0] SRC_B_FOUR    = 3'b001;
    localparam logic [2:0] SRC_B_IMM     = 3'b010;
    localparam logic [2:0] SRC_B_IMM_SH2 = 3'b011;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_EXC    = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [4:0] {
        S_RESET       = 5'd0,
        S_FETCH       = 5'd1,
        S_FETCH_LATCH = 5'd2,
        S_DECODE      = 5'd3,
        S_R_EXEC      = 5'd4,
        S_R_WB        = 5'd5,
        S_ADDI_EXEC   = 5'd6,
        S_ADDI_WB     = 5'd7,
        S_MEM_ADDR    = 5'd8,
        S_LW_WAIT     = 5'd9,
        S_LW_WB       = 5'd10,
        S_SW_WRITE    = 5'd11,
        S_BEQ         = 5'd12,
        S_JUMP        = 5'd13,
        S_TRAP        = 5'd14
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [2:0]       r_rtype_alu_op;
    logic             r_is_lw;
    logic             w_wait_done;
    logic             w_funct_ok;
    logic [2:0]       w_funct_alu_op;

    assign w_wait_done = (r_wait_cnt == CNT_LAST);
    assign state       = STATE_W'(r_state);

    always_comb begin
        w_funct_ok     = 1'b1;
        w_funct_alu_op = ALU_ADD;
        case (funct)
            FN_ADD:  w_funct_alu_op = ALU_ADD;
            FN_SUB:  w_funct_alu_op = ALU_SUB;
            FN_AND:  w_funct_alu_op = ALU_AND;
            FN_OR:   w_funct_alu_op = ALU_OR;
            FN_SLT:  w_funct_alu_op = ALU_SLT;
            default: w_funct_ok     = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_RESET;
            r_wait_cnt     <= '0;
            r_rtype_alu_op <= ALU_ADD;
            r_is_lw        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_FETCH || r_state == S_LW_WAIT) && !w_wait_done)
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
            // IR fields are only trusted while decoding; keep what later states need.
            if (r_state == S_DECODE) begin
                r_rtype_alu_op <= w_funct_alu_op;
                r_is_lw        <= (op_code == OP_LW);
            end
        end
    end

    always_comb begin
        w_next_state = S_RESET;
        case (r_state)
            S_RESET:       w_next_state = S_FETCH;
            S_FETCH:       w_next_state = w_wait_done ? S_FETCH_LATCH : S_FETCH;
            S_FETCH_LATCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (op_code)
                    OP_RTYPE:     w_next_state = w_funct_ok ? S_R_EXEC : S_TRAP;
                    OP_ADDI:      w_next_state = S_ADDI_EXEC;
                    OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
                    OP_BEQ:       w_next_state = S_BEQ;
                    OP_J:         w_next_state = S_JUMP;
                    default:      w_next_state = S_TRAP;
                endcase
            end
            S_R_EXEC:      w_next_state = S_R_WB;
            S_R_WB:        w_next_state = S_FETCH;
            S_ADDI_EXEC:   w_next_state = S_ADDI_WB;
            S_ADDI_WB:     w_next_state = S_FETCH;
            S_MEM_ADDR:    w_next_state = r_is_lw ? S_LW_WAIT : S_SW_WRITE;
            S_LW_WAIT:     w_next_state = w_wait_done ? S_LW_WB : S_LW_WAIT;
            S_LW_WB:       w_next_state = S_FETCH;
            S_SW_WRITE:    w_next_state = S_FETCH;
            S_BEQ:         w_next_state = S_FETCH;
            S_JUMP:        w_next_state = S_FETCH;
            S_TRAP:        w_next_state = S_FETCH;
            default:       w_next_state = S_RESET;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = PC_SRC_ALU;
        memory_write  = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_OP_W'(ALU_PASSA);
        alu_out_write = 1'b0;
        illegal       = 1'b0;
        case (r_state)
            S_FETCH_LATCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_OP_W'(ALU_ADD);
            end
            S_DECODE: begin
                alu_src_b     = SRC_B_IMM_SH2;
                alu_op        = ALU_OP_W'(ALU_ADD);
                alu_out_write = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_W'(r_rtype_alu_op);
                alu_out_write = 1'b1;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDI_EXEC, S_MEM_ADDR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRC_B_IMM;
                alu_op        = ALU_OP_W'(ALU_ADD);
                alu_out_write = 1'b1;
            end
            S_ADDI_WB:  reg_write = 1'b1;
            S_LW_WAIT:  i_or_d = 1'b1;
            S_LW_WB: begin
                i_or_d     = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_SW_WRITE: begin
                i_or_d       = 1'b1;
                memory_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_OP_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_SRC_JUMP;
            end
            S_TRAP: begin
                illegal   = 1'b1;
                pc_write  = 1'b1;
                pc_source = PC_SRC_EXC;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: three instances (MEM_LATENCY 1..3) run directed and random
// instructions; each cycle's control word is compared with a per-instruction expected trace.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       memory_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [2:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       illegal;
    } ctrl_t;

    logic             clock = 1'b0;
    logic [2:0]       reset_v = 3'b111;
    logic [5:0]       op_v [3];
    logic [5:0]       fn_v [3];
    ctrl_t [2:0]      obs;
    logic [2:0][4:0]  st_v;
    logic [4:0]       st_rst [3];
    bit   [2:0]       just_reset = 3'b000;

    int    n_vec = 0;
    int    n_err = 0;
    ctrl_t exp_q [$];
    int    dec_idx;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       w_i_or_d, w_ir_write, w_pc_write, w_pc_write_cond, w_memory_write;
        logic       w_reg_write, w_mem_to_reg, w_reg_dst, w_alu_src_a, w_alu_out_write, w_illegal;
        logic [1:0] w_pc_source;
        logic [2:0] w_alu_src_b, w_alu_op;
        logic [4:0] w_state;

        mc_ctrl_fsm #(.MEM_LATENCY(g + 1), .ALU_OP_W(3), .STATE_W(5)) u_dut (
            .clock         (clock),
            .reset         (reset_v[g]),
            .op_code       (op_v[g]),
            .funct         (fn_v[g]),
            .i_or_d        (w_i_or_d),
            .ir_write      (w_ir_write),
            .pc_write      (w_pc_write),
            .pc_write_cond (w_pc_write_cond),
            .pc_source     (w_pc_source),
            .memory_write  (w_memory_write),
            .reg_write     (w_reg_write),
            .mem_to_reg    (w_mem_to_reg),
            .reg_dst       (w_reg_dst),
            .alu_src_a     (w_alu_src_a),
            .alu_src_b     (w_alu_src_b),
            .alu_op        (w_alu_op),
            .alu_out_write (w_alu_out_write),
            .illegal       (w_illegal),
            .state         (w_state)
        );

        assign obs[g] = {w_i_or_d, w_ir_write, w_pc_write, w_pc_write_cond, w_pc_source,
                         w_memory_write, w_reg_write, w_mem_to_reg, w_reg_dst, w_alu_src_a,
                         w_alu_src_b, w_alu_op, w_alu_out_write, w_illegal};
        assign st_v[g] = w_state;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%05h, expected 0x%05h", tag, got, exp);
        end
    endtask

    function automatic bit is_rtype_fn(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] fn);
        case (fn)
            6'h22:   return 3'b010;
            6'h24:   return 3'b011;
            6'h25:   return 3'b100;
            6'h2A:   return 3'b101;
            default: return 3'b001;
        endcase
    endfunction

    // Expected control word for every cycle of one instruction, FETCH entry to the next FETCH.
    task automatic build(input int ml, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        ctrl_t exec_imm;
        exp_q.delete();
        repeat (ml) exp_q.push_back('0);
        c = '0; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 3'b001; c.alu_op = 3'b001;
        exp_q.push_back(c);
        c = '0; c.alu_src_b = 3'b011; c.alu_op = 3'b001; c.alu_out_write = 1;
        exp_q.push_back(c);
        dec_idx = ml + 1;
        exec_imm = '0; exec_imm.alu_src_a = 1; exec_imm.alu_src_b = 3'b010;
        exec_imm.alu_op = 3'b001; exec_imm.alu_out_write = 1;
        if (op == 6'h00 && is_rtype_fn(fn)) begin
            c = '0; c.alu_src_a = 1; c.alu_op = rtype_alu(fn); c.alu_out_write = 1;
            exp_q.push_back(c);
            c = '0; c.reg_write = 1; c.reg_dst = 1;
            exp_q.push_back(c);
        end else if (op == 6'h08) begin
            exp_q.push_back(exec_imm);
            c = '0; c.reg_write = 1;
            exp_q.push_back(c);
        end else if (op == 6'h23) begin
            exp_q.push_back(exec_imm);
            c = '0; c.i_or_d = 1;
            repeat (ml) exp_q.push_back(c);
            c.reg_write = 1; c.mem_to_reg = 1;
            exp_q.push_back(c);
        end else if (op == 6'h2B) begin
            exp_q.push_back(exec_imm);
            c = '0; c.i_or_d = 1; c.memory_write = 1;
            exp_q.push_back(c);
        end else if (op == 6'h04) begin
            c = '0; c.alu_src_a = 1; c.alu_op = 3'b010; c.pc_write_cond = 1; c.pc_source = 2'b01;
            exp_q.push_back(c);
        end else if (op == 6'h02) begin
            c = '0; c.pc_write = 1; c.pc_source = 2'b10;
            exp_q.push_back(c);
        end else begin
            c = '0; c.illegal = 1; c.pc_write = 1; c.pc_source = 2'b11;
            exp_q.push_back(c);
        end
    endtask

    // Entered at a negedge; reset is held across three rising edges.
    task automatic do_reset(input int d);
        reset_v[d] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check($sformatf("ml%0d reset cyc%0d", d + 1, k), 32'(obs[d]), 32'd0);
            if (k == 0) st_rst[d] = st_v[d];
            else check($sformatf("ml%0d reset state hold", d + 1), 32'(st_v[d] == st_rst[d]), 32'd1);
            op_v[d] = 6'($urandom);
            fn_v[d] = 6'($urandom);
        end
        reset_v[d] = 1'b0;
        just_reset[d] = 1'b1;
    endtask

    // IR fields carry junk in every cycle except DECODE, where the real instruction is shown.
    task automatic run_insn(input int d, input logic [5:0] op, input logic [5:0] fn,
                            input int abort_at, input string name);
        build(d + 1, op, fn);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            if (i == 0 && just_reset[d]) begin
                check($sformatf("ml%0d state leaves reset", d + 1), 32'(st_v[d] != st_rst[d]), 32'd1);
                just_reset[d] = 1'b0;
            end
            check($sformatf("ml%0d %s op%02h fn%02h cyc%0d", d + 1, name, op, fn, i),
                  32'(obs[d]), 32'(exp_q[i]));
            if (i == dec_idx) begin
                op_v[d] = op;
                fn_v[d] = fn;
            end else begin
                op_v[d] = 6'($urandom);
                fn_v[d] = 6'($urandom);
            end
            if (i == abort_at) begin
                do_reset(d);
                return;
            end
        end
    endtask

    task automatic rand_insn(output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] legal_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        int k = $urandom_range(0, 9);
        fn = 6'($urandom);
        case (k)
            0, 1, 2: begin op = 6'h00; fn = legal_fn[$urandom_range(0, 4)]; end
            3:       op = 6'h00;
            4:       op = 6'h08;
            5:       op = 6'h23;
            6:       op = 6'h2B;
            7:       op = 6'h04;
            8:       op = 6'h02;
            default: op = 6'($urandom);
        endcase
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        for (int g = 0; g < 3; g++) begin
            op_v[g] = 6'h00;
            fn_v[g] = 6'h00;
        end
        for (int d = 0; d < 3; d++) begin
            do_reset(d);
            run_insn(d, 6'h00, 6'h20, -1, "add");
            run_insn(d, 6'h00, 6'h22, -1, "sub");
            run_insn(d, 6'h00, 6'h24, -1, "and");
            run_insn(d, 6'h00, 6'h25, -1, "or");
            run_insn(d, 6'h00, 6'h2A, -1, "slt");
            run_insn(d, 6'h08, 6'h00, -1, "addi");
            run_insn(d, 6'h23, 6'h11, -1, "lw");
            run_insn(d, 6'h2B, 6'h00, -1, "sw");
            run_insn(d, 6'h04, 6'h00, -1, "beq");
            run_insn(d, 6'h02, 6'h00, -1, "j");
            run_insn(d, 6'h3F, 6'h00, -1, "trap_op");
            run_insn(d, 6'h00, 6'h3F, -1, "trap_fn");
            run_insn(d, 6'h23, 6'h00, (d + 1) + 3 + (d + 1) / 2, "lw_reset");
            run_insn(d, 6'h00, 6'h2A, -1, "slt_after_reset");
            for (int n = 0; n < 40; n++) begin
                rand_insn(op, fn);
                run_insn(d, op, fn, -1, "rand");
            end
            reset_v[d] = 1'b1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
